// File: rtl/vram_pkg.sv
// Shared widths and the read-owner tag used to route VRAM read data
// back to either the scan-out path or the CPU.
package vram_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_e;

endpackage

// File: rtl/vram_fetch_sched.sv
// Video fetch scheduler: paces framebuffer reads across the active part of
// each line and walks the framebuffer address through the frame.
module vram_fetch_sched
    import vram_pkg::*;
#(
    parameter int                ADDR_W         = DEF_ADDR_W,
    parameter int                FETCH_INTERVAL = 8,
    parameter int                LINE_WORDS     = 40,
    parameter logic [ADDR_W-1:0] VID_BASE       = '0,
    parameter int                FRAME_WORDS    = 19200
)(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hbright_i,
    input  logic              vbright_i,
    output logic              vid_slot_o,
    output logic [ADDR_W-1:0] vid_addr_o
);

    localparam int PH_W = $clog2(FETCH_INTERVAL);
    localparam int LW_W = $clog2(LINE_WORDS + 1);
    localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(FETCH_INTERVAL - 1);
    localparam logic [LW_W-1:0]   LW_MAX   = LW_W'(LINE_WORDS);
    localparam logic [ADDR_W-1:0] VID_LAST = VID_BASE + ADDR_W'(FRAME_WORDS - 1);

    logic              hb_q;
    logic [PH_W-1:0]   ph_q, ph_cur, ph_d;
    logic [LW_W-1:0]   lw_q, lw_cur, lw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rise;
    logic              slot;

    // The line-start edge takes effect in the same cycle, so the first
    // slot of a line is decided on the hBright rising cycle itself.
    assign rise = hbright_i & ~hb_q;

    always_comb begin
        ph_cur = rise ? '0 : ph_q;
        lw_cur = rise ? '0 : lw_q;
        slot   = hbright_i & vbright_i & (ph_cur == '0) & (lw_cur < LW_MAX);
        ph_d   = (ph_cur == PH_LAST) ? '0 : ph_cur + 1'b1;
        lw_d   = slot ? lw_cur + 1'b1 : lw_cur;
        addr_d = addr_q;
        if (!vbright_i) begin
            addr_d = VID_BASE;
        end else if (slot) begin
            addr_d = (addr_q == VID_LAST) ? VID_BASE : addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hb_q   <= 1'b0;
            ph_q   <= '0;
            lw_q   <= '0;
            addr_q <= VID_BASE;
        end else begin
            hb_q   <= hbright_i;
            ph_q   <= ph_d;
            lw_q   <= lw_d;
            addr_q <= addr_d;
        end
    end

    assign vid_slot_o = slot;
    assign vid_addr_o = addr_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetch slots take priority, the CPU gets
// every other cycle; read data is steered back by a two-stage owner tag.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int                ADDR_W         = DEF_ADDR_W,
    parameter int                DATA_W         = DEF_DATA_W,
    parameter int                FETCH_INTERVAL = 8,
    parameter int                LINE_WORDS     = 40,
    parameter logic [ADDR_W-1:0] VID_BASE       = '0,
    parameter int                FRAME_WORDS    = 19200
)(
    input  logic              CLK,
    input  logic              CLR,
    input  logic              hBright,
    input  logic              vBright,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_data
);

    logic              vid_slot;
    logic [ADDR_W-1:0] vid_addr;
    logic              cpu_grant;
    logic              cpu_busy_q, cpu_busy_d;
    logic              wack_q;
    logic              mem_en_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q, vid_data_q;
    owner_e            tag_p0_q, tag_p1_q, tag_d;

    vram_fetch_sched #(
        .ADDR_W        (ADDR_W),
        .FETCH_INTERVAL(FETCH_INTERVAL),
        .LINE_WORDS    (LINE_WORDS),
        .VID_BASE      (VID_BASE),
        .FRAME_WORDS   (FRAME_WORDS)
    ) u_sched (
        .clk_i     (CLK),
        .rst_i     (CLR),
        .hbright_i (hBright),
        .vbright_i (vBright),
        .vid_slot_o(vid_slot),
        .vid_addr_o(vid_addr)
    );

    assign cpu_grant = cpu_req & ~vid_slot & ~cpu_busy_q;

    always_comb begin
        tag_d = OWN_NONE;
        if (vid_slot) begin
            tag_d = OWN_VID;
        end else if (cpu_grant && !cpu_we) begin
            tag_d = OWN_CPU;
        end
        // Busy stays up through the ack cycle so a still-held request is not re-granted.
        cpu_busy_d = cpu_busy_q;
        if (cpu_grant) begin
            cpu_busy_d = 1'b1;
        end else if (cpu_ack) begin
            cpu_busy_d = 1'b0;
        end
    end

    // Issue stage: decision registered onto the VRAM port; tag enters p0.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wack_q      <= 1'b0;
            cpu_busy_q  <= 1'b0;
            tag_p0_q    <= OWN_NONE;
            tag_p1_q    <= OWN_NONE;
            cpu_rdata_q <= '0;
            vid_data_q  <= '0;
        end else begin
            mem_en_q   <= vid_slot | cpu_grant;
            mem_we_q   <= cpu_grant & cpu_we;
            wack_q     <= cpu_grant & cpu_we;
            cpu_busy_q <= cpu_busy_d;
            if (vid_slot) begin
                mem_addr_q <= vid_addr;
            end else if (cpu_grant) begin
                mem_addr_q <= cpu_addr;
            end
            if (cpu_grant && cpu_we) begin
                mem_wdata_q <= cpu_wdata;
            end
            // Return stage: tag p1 lines up with mem_rdata from the VRAM.
            tag_p0_q <= tag_d;
            tag_p1_q <= tag_p0_q;
            if (tag_p1_q == OWN_CPU) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (tag_p1_q == OWN_VID) begin
                vid_data_q <= mem_rdata;
            end
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_ack   = wack_q | (tag_p1_q == OWN_CPU);
    assign cpu_rdata = (tag_p1_q == OWN_CPU) ? mem_rdata : cpu_rdata_q;
    assign vid_valid = (tag_p1_q == OWN_VID);
    assign vid_data  = (tag_p1_q == OWN_VID) ? mem_rdata : vid_data_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a synchronous-read VRAM model that
// returns the inverted address as data.
module tb_vram_arbiter;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic        hBright = 1'b0;
    logic        vBright = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        vid_valid;
    logic [15:0] vid_data;

    int n_chk = 0;
    int n_err = 0;

    vram_arbiter #(
        .ADDR_W        (16),
        .DATA_W        (16),
        .FETCH_INTERVAL(8),
        .LINE_WORDS    (4),
        .VID_BASE      (16'h0100),
        .FRAME_WORDS   (8)
    ) dut (
        .CLK      (CLK),
        .CLR      (CLR),
        .hBright  (hBright),
        .vBright  (vBright),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ack  (cpu_ack),
        .cpu_rdata(cpu_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .vid_valid(vid_valid),
        .vid_data (vid_data)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (mem_en && !mem_we) mem_rdata <= ~mem_addr;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"},    32'(mem_en),    0);
        chk({tag, "_we"},    32'(mem_we),    0);
        chk({tag, "_addr"},  32'(mem_addr),  0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_ack"},   32'(cpu_ack),   0);
        chk({tag, "_rdata"}, 32'(cpu_rdata), 0);
        chk({tag, "_vv"},    32'(vid_valid), 0);
        chk({tag, "_vd"},    32'(vid_data),  0);
    endtask

    initial begin
        step(); step(); step();
        chk_all_zero("rst");
        CLR = 1'b0;
        step();

        // 1: CPU write during blanking
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
        step();
        chk("t1_en",    32'(mem_en),    1);
        chk("t1_we",    32'(mem_we),    1);
        chk("t1_addr",  32'(mem_addr),  32'h0010);
        chk("t1_wdata", 32'(mem_wdata), 32'hBEEF);
        chk("t1_ack",   32'(cpu_ack),   1);
        step();
        cpu_req = 1'b0;
        chk("t1_ack2",  32'(cpu_ack),   0);
        chk("t1_en2",   32'(mem_en),    0);
        chk("t1_hold",  32'(mem_addr),  32'h0010);
        step();
        chk("t1_en3",   32'(mem_en),    0);

        // 2: CPU read during blanking
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
        step();
        chk("t2_en",    32'(mem_en),    1);
        chk("t2_we",    32'(mem_we),    0);
        chk("t2_addr",  32'(mem_addr),  32'h0020);
        chk("t2_ack1",  32'(cpu_ack),   0);
        step();
        chk("t2_ack",   32'(cpu_ack),   1);
        chk("t2_rdata", 32'(cpu_rdata), 32'hFFDF);
        chk("t2_en2",   32'(mem_en),    0);
        cpu_req = 1'b0;
        step();
        chk("t2_ack3",  32'(cpu_ack),   0);
        chk("t2_hold",  32'(cpu_rdata), 32'hFFDF);

        // 3: one active line, four fetches spaced by eight clocks
        vBright = 1'b1; hBright = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            if ((k % 8 == 1) && (k <= 25)) begin
                chk("t3_en",   32'(mem_en),   1);
                chk("t3_we",   32'(mem_we),   0);
                chk("t3_addr", 32'(mem_addr), 32'h0100 + (k / 8));
            end else begin
                chk("t3_idle", 32'(mem_en),   0);
            end
            if ((k % 8 == 2) && (k <= 26)) begin
                chk("t3_vv", 32'(vid_valid), 1);
                chk("t3_vd", 32'(vid_data),  32'hFEFF - (k / 8));
            end else begin
                chk("t3_novv", 32'(vid_valid), 0);
            end
        end
        hBright = 1'b0; vBright = 1'b0;
        step();

        // 4: CPU write colliding with the first slot of a line
        vBright = 1'b1; hBright = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 16'h1234;
        step();
        chk("t4_ven",   32'(mem_en),    1);
        chk("t4_vwe",   32'(mem_we),    0);
        chk("t4_vaddr", 32'(mem_addr),  32'h0100);
        chk("t4_ack0",  32'(cpu_ack),   0);
        step();
        chk("t4_cen",   32'(mem_en),    1);
        chk("t4_cwe",   32'(mem_we),    1);
        chk("t4_caddr", 32'(mem_addr),  32'h0030);
        chk("t4_cwd",   32'(mem_wdata), 32'h1234);
        chk("t4_ack",   32'(cpu_ack),   1);
        chk("t4_vv",    32'(vid_valid), 1);
        chk("t4_vd",    32'(vid_data),  32'hFEFF);
        cpu_req = 1'b0;
        step();
        chk("t4_ack2",  32'(cpu_ack),   0);
        hBright = 1'b0; vBright = 1'b0;
        step();

        // 5: two lines walk 0100..0107, third line wraps to 0100
        vBright = 1'b1;
        for (int ln = 0; ln < 2; ln++) begin
            hBright = 1'b1;
            for (int k = 1; k <= 32; k++) begin
                step();
                if ((k % 8 == 1) && (k <= 25)) begin
                    chk("t5_en",   32'(mem_en),   1);
                    chk("t5_addr", 32'(mem_addr), 32'h0100 + ln * 4 + (k / 8));
                end
            end
            hBright = 1'b0;
            step(); step();
        end
        hBright = 1'b1;
        step();
        chk("t5_wrap_en",   32'(mem_en),   1);
        chk("t5_wrap_addr", 32'(mem_addr), 32'h0100);
        for (int k = 2; k <= 9; k++) step();
        chk("t5_l3_addr", 32'(mem_addr), 32'h0101);
        vBright = 1'b0; hBright = 1'b0;
        step(); step();
        vBright = 1'b1; hBright = 1'b1;
        step();
        chk("t5_frame_en",   32'(mem_en),   1);
        chk("t5_frame_addr", 32'(mem_addr), 32'h0100);
        hBright = 1'b0;
        step(); step();

        // 6: reset during an in-flight CPU read; vid_addr sits at 0101 beforehand
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
        step();
        chk("t6_en", 32'(mem_en), 1);
        chk("t6_addr", 32'(mem_addr), 32'h0040);
        CLR = 1'b1; cpu_req = 1'b0;
        step();
        chk_all_zero("t6");
        CLR = 1'b0;
        step();
        chk("t6_ack", 32'(cpu_ack), 0);
        hBright = 1'b1;
        step();
        chk("t6_ven",   32'(mem_en),   1);
        chk("t6_vaddr", 32'(mem_addr), 32'h0100);
        hBright = 1'b0; vBright = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
